// File: rtl/interrupt_scheduler_mipi_if.sv
// interrupt_scheduler_mipi_if: controller status/mask/clear and CPU vector handshake bundle
interface interrupt_scheduler_mipi_if #(
    parameter int NUM_SRC   = 8,
    parameter int VEC_WIDTH = 3
);
    logic                 sched_en;
    logic [NUM_SRC-1:0]   status;
    logic [NUM_SRC-1:0]   src_mask;
    logic                 irq_ack;
    logic                 irq_valid;
    logic [VEC_WIDTH-1:0] irq_vector;
    logic [NUM_SRC-1:0]   interrupt_clear;
    logic                 spurious;
    logic                 busy;
    logic [15:0]          served_cnt;
    logic                 timeout;
    modport slave (
        input  sched_en, status, src_mask, irq_ack,
        output irq_valid, irq_vector, interrupt_clear, spurious, busy, served_cnt, timeout
    );
    modport master (
        output sched_en, status, src_mask, irq_ack,
        input  irq_valid, irq_vector, interrupt_clear, spurious, busy, served_cnt, timeout
    );
endinterface

// File: rtl/interrupt_scheduler_mipi.sv
// interrupt_scheduler_mipi: round-robin presentation of pending interrupts with ack, clear pulse and holdoff
// Optional ack timeout with forced clear enabled by INTERRUPT_SCHED_TIMEOUT_EN.
module interrupt_scheduler_mipi #(
    parameter int NUM_SRC   = 8,
    parameter int VEC_WIDTH = 3,
    parameter int HOLDOFF   = 4,
    parameter int TIMEOUT   = 1023
) (
    input logic sys_clk,
    input logic rst,
    interrupt_scheduler_mipi_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARB, PRESENT, CLEAR, HOLD} state_t;
    state_t               state;
    logic [VEC_WIDTH-1:0] rr_ptr;
    logic [VEC_WIDTH-1:0] pick;
    logic [3:0]           hold_cnt;
    logic [NUM_SRC-1:0]   pend;
    logic [NUM_SRC-1:0]   rot;
    if (HOLDOFF < 1 || HOLDOFF > 15 || TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_cfg
        $error("interrupt_scheduler_mipi: HOLDOFF or TIMEOUT out of range");
    end
    assign pend = bus.status & bus.src_mask;
    assign rot  = NUM_SRC'({pend, pend} >> rr_ptr);
    assign bus.busy = state != IDLE;
    // rot[0] is the rr_ptr position, so the lowest set bit of rot is the round-robin winner
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (rot[i]) pick = (int'(rr_ptr) + i >= NUM_SRC) ? VEC_WIDTH'(int'(rr_ptr) + i - NUM_SRC)
                                                             : VEC_WIDTH'(int'(rr_ptr) + i);
    end
`ifdef INTERRUPT_SCHED_TIMEOUT_EN
    logic [9:0] tmo_cnt;
`else
    assign bus.timeout = 1'b0;
`endif
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            hold_cnt            <= '0;
            bus.irq_valid       <= 1'b0;
            bus.irq_vector      <= '0;
            bus.interrupt_clear <= '0;
            bus.spurious        <= 1'b0;
            bus.served_cnt      <= '0;
`ifdef INTERRUPT_SCHED_TIMEOUT_EN
            tmo_cnt             <= '0;
            bus.timeout         <= 1'b0;
`endif
        end else begin
            bus.interrupt_clear <= '0;
            bus.spurious        <= 1'b0;
            case (state)
                IDLE: if (bus.sched_en && |pend) state <= ARB;
                ARB: begin
                    state <= |pend ? PRESENT : IDLE;
                    if (|pend) bus.irq_vector <= pick;
`ifdef INTERRUPT_SCHED_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                PRESENT: begin
                    if (bus.irq_ack && bus.irq_valid) begin
                        state         <= CLEAR;
                        bus.irq_valid <= 1'b0;
                        if (bus.served_cnt != 16'hFFFF) bus.served_cnt <= bus.served_cnt + 16'd1;
                    end
`ifdef INTERRUPT_SCHED_TIMEOUT_EN
                    else if (bus.irq_valid && tmo_cnt == 10'(TIMEOUT - 1)) begin
                        state         <= CLEAR;
                        bus.irq_valid <= 1'b0;
                        bus.timeout   <= 1'b1;
                    end
`endif
                    else if (!bus.status[bus.irq_vector]) begin
                        state         <= IDLE;
                        bus.irq_valid <= 1'b0;
                        bus.spurious  <= 1'b1;
                    end else begin
                        bus.irq_valid <= 1'b1;
`ifdef INTERRUPT_SCHED_TIMEOUT_EN
                        tmo_cnt <= tmo_cnt + 10'(bus.irq_valid);
`endif
                    end
                end
                CLEAR: begin
                    state               <= HOLD;
                    bus.interrupt_clear <= NUM_SRC'(1) << bus.irq_vector;
                    rr_ptr              <= (bus.irq_vector == VEC_WIDTH'(NUM_SRC - 1)) ? '0 : bus.irq_vector + 1'b1;
                    hold_cnt            <= 4'(HOLDOFF - 1);
                end
                HOLD: begin
                    if (hold_cnt == '0) state <= IDLE;
                    else hold_cnt <= hold_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/interrupt_scheduler_mipi.md
Name: interrupt_scheduler_mipi

Overview:
Sequences service of the pending interrupt status bits produced by the MIPI interrupt controller. It presents one source at a time to the processor as a vector with a valid/ack handshake, using round-robin priority. On ack it issues the per-source one-cycle clear pulse back to the controller, then waits a programmable holdoff while the controller's status and counters settle. It sits between the interrupt controller's status/clear ports and the CPU-facing register interface.

Parameters:
NUM_SRC, 8, number of interrupt sources (must match the controller's status width)
VEC_WIDTH, 3, width of the vector output; 2**VEC_WIDTH >= NUM_SRC
HOLDOFF, 4, cycles spent in HOLD after a clear pulse; legal range 1..15
TIMEOUT, 1023, ack timeout in cycles; used only with the optional feature

Ports:
sys_clk_i  input  1  system clock; all logic on its rising edge
rst_i  input  1  synchronous, active-high reset
sched_en_i  input  1  scheduler enable; sampled only in IDLE
status_i  input  NUM_SRC  pending status from the interrupt controller
src_mask_i  input  NUM_SRC  1 = source eligible for scheduling
irq_ack_i  input  1  CPU acknowledge of the presented vector
irq_valid_o  output  1  vector presented, awaiting ack
irq_vector_o  output  VEC_WIDTH  index of the presented source
interrupt_clear_o  output  NUM_SRC  one-hot, one-cycle clear pulse to the controller
spurious_o  output  1  one-cycle pulse when a presented source withdrew before ack
busy_o  output  1  state != IDLE
served_cnt_o  output  16  saturating count of acknowledged interrupts
timeout_o  output  1  sticky ack-timeout flag

Behaviour:
- Reset (rst_i=1 at an edge):
  - State goes to IDLE; round-robin pointer rr_ptr=0.
  - All outputs 0; served_cnt_o=0; timeout_o=0; hold counter=0.
  - Reset asserted in any state aborts the transaction. No clear pulse is issued.
- pend = status_i & src_mask_i.
- IDLE:
  - If sched_en_i && |pend, go to ARB. Otherwise stay.
- ARB (1 cycle):
  - Select the first set bit of pend, searching upward from rr_ptr and wrapping NUM_SRC-1 -> 0.
  - Latch the selection into irq_vector_o and go to PRESENT.
  - If pend became 0, return to IDLE.
- PRESENT:
  - irq_valid_o=1; irq_vector_o is held stable.
  - irq_ack_i && irq_valid_o: go to CLEAR; served_cnt_o increments, saturating at 16'hFFFF.
  - Else, if status_i[vec]==0 (cleared externally): irq_valid_o drops, spurious_o pulses for 1 cycle, go to IDLE. rr_ptr is unchanged.
  - When ack and withdrawal occur in the same cycle, ack wins.
- CLEAR (1 cycle):
  - interrupt_clear_o = 1<<vec; irq_valid_o=0.
  - rr_ptr = (vec==NUM_SRC-1) ? 0 : vec+1.
  - Go to HOLD.
- HOLD:
  - Lasts exactly HOLDOFF cycles, then go to IDLE. pend is not sampled during HOLD.
- Latency:
  - pend sampled high in IDLE at edge k: irq_valid_o is high after edge k+2.
  - Ack sampled at edge m: clear pulse during cycle m+1..m+2; IDLE after HOLDOFF further cycles.
- Enable and mask:
  - sched_en_i low has no effect outside IDLE; an in-flight transaction completes.
  - src_mask_i changes are honoured at the next ARB only.
- irq_ack_i outside PRESENT is ignored.
- interrupt_clear_o is never multi-hot.

Optional Feature:
- Macro: INTERRUPT_SCHED_TIMEOUT_EN
- Defined:
  - A 10-bit counter runs in PRESENT, cleared on entry.
  - When it reaches TIMEOUT without ack: timeout_o set (sticky until reset) and the FSM goes to CLEAR (forced clear). served_cnt_o is not incremented.
- Undefined:
  - PRESENT waits indefinitely.
  - timeout_o is tied 0 and no counter is instantiated.

Test Plan:
1. Reset, then status_i=8'h00, sched_en_i=1 for 20 cycles -> busy_o=0, irq_valid_o=0, interrupt_clear_o=0 throughout.
2. status_i=8'h24, mask=8'hFF, ack 3 cycles after each valid; controller model clears the bit on pulse -> vector 2 served (clear 8'h04), then vector 5 (clear 8'h20); served_cnt_o=2; HOLD lasts 4 cycles each.
3. Round-robin: status_i held at 8'h81, ack each immediately, controller does not clear -> vectors alternate 0,7,0,7.
4. status_i=8'h10 presented; drop status_i[4] before ack -> spurious_o one pulse, no clear pulse, FSM back to IDLE, served_cnt_o unchanged.
5. Ack coincident with withdrawal -> clear 8'h10 issued, spurious_o=0. rst_i asserted mid-PRESENT -> next cycle all outputs 0, no clear pulse.
6. With INTERRUPT_SCHED_TIMEOUT_EN, TIMEOUT=16, never ack -> timeout_o=1 at 16 cycles after valid, clear pulse issued, served_cnt_o=0. Without the macro -> valid held for 2000 cycles, timeout_o=0.
